seq_accum: RTL and testbench

Stream-side responder for the sequential-logic exercises: accepts a stream of data beats on a valid/ready input, sums each fixed-length packet of `BEATS` beats, and presents the packet sum on a valid/ready output. The output register is independent of the accumulator, so packet N+1 accumulates while sum N waits for the consumer. The testbench drives it at the input and back-pressures it at the output.

---
 rtl/seq_accum.sv | 130 +++++++++++++
 tb/tb_seq_accum.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_accum.sv
// seq_accum: sums each packet of BEATS input beats and holds the sum in an
// independent valid/ready output register. Define SEQ_ACCUM_SATURATE_EN for saturating adds.
module seq_accum #(
  parameter int DATA_W = 8,
  parameter int BEATS  = 4,
  parameter int SUM_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [15:0]       pkt_count,
  output logic              busy
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  out_state_e        state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              last_beat_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic [SUM_W-1:0]  sum_s;

  function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [SUM_W:0] wide;
    wide = {1'b0, a} + {{(SUM_W + 1 - DATA_W){1'b0}}, b};
`ifdef SEQ_ACCUM_SATURATE_EN
    if (wide[SUM_W]) begin
      acc_add = '1;
    end else begin
      acc_add = wide[SUM_W-1:0];
    end
`else
    acc_add = wide[SUM_W-1:0];
`endif
  endfunction

  // Ready only drops when the last beat would have nowhere to go.
  assign last_beat_s = (beat_cnt_q == LAST_BEAT);
  assign in_ready    = !(last_beat_s && (state_q == FULL) && !out_ready);
  assign in_fire_s   = in_valid && in_ready;
  assign out_fire_s  = (state_q == FULL) && out_ready;
  assign sum_s       = acc_add(acc_q, in_data);

  assign out_valid = (state_q == FULL);
  assign out_sum   = out_sum_q;
  assign pkt_count = pkt_count_q;
  assign busy      = (beat_cnt_q != '0);

  // Next-state for accumulator, output register and packet counter.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    out_sum_d   = out_sum_q;
    pkt_count_d = pkt_count_q;

    if (in_fire_s) begin
      if (last_beat_s) begin
        out_sum_d  = sum_s;
        acc_d      = '0;
        beat_cnt_d = '0;
      end else begin
        acc_d      = sum_s;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end else begin
      acc_d      = acc_q;
      beat_cnt_d = beat_cnt_q;
    end

    case (state_q)
      EMPTY: begin
        if (in_fire_s && last_beat_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // A consume with a simultaneous last beat refills the register in place.
        if (out_fire_s && !(in_fire_s && last_beat_s)) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (out_fire_s) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      out_sum_q   <= '0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      out_sum_q   <= out_sum_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_seq_accum.sv
// Scoreboard bench for seq_accum (SUM_W=9): stimulus pushes expected sums,
// a negedge monitor pops and compares on every output handshake.
module tb_seq_accum;
  localparam int DATA_W = 8;
  localparam int BEATS  = 4;
  localparam int SUM_W  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [15:0]       pkt_count;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  logic [SUM_W-1:0] exp_q[$];
  int unsigned cons_n;
  bit rnd_mode;

  always #5 clk = ~clk;

  seq_accum #(.DATA_W(DATA_W), .BEATS(BEATS), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .pkt_count(pkt_count), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [SUM_W-1:0] model_add(input logic [SUM_W-1:0] a, input logic [DATA_W-1:0] b);
    int t;
    t = int'(a) + int'(b);
`ifdef SEQ_ACCUM_SATURATE_EN
    if (t > 511) t = 511;
`else
    t = t % 512;
`endif
    return t[SUM_W-1:0];
  endfunction

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      cons_n = 0;
    end else if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", out_sum);
      end else begin
        logic [SUM_W-1:0] e;
        e = exp_q.pop_front();
        checks--;
        check("out_sum", 32'(out_sum), 32'(e));
      end
      check("pkt_count_at_consume", 32'(pkt_count), 32'(cons_n[15:0]));
      cons_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
      if (!ok) waits++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout actual=not_accepted required=accepted data=%0h", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [SUM_W-1:0] s;
    logic [DATA_W-1:0] d;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rnd_mode = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);
    end
    tick();

    // Basic packet, back-to-back beats
    out_ready = 1'b1;
    exp_q.push_back(9'h0A0);
    send_beat(8'h10, w); send_beat(8'h20, w); send_beat(8'h30, w); send_beat(8'h40, w);
    check("basic_valid_rise", 32'(out_valid), 32'd1);
    check("basic_sum_direct", 32'(out_sum), 32'h0A0);
    tick();
    check("basic_valid_fall", 32'(out_valid), 32'd0);
    check("basic_pkt_count", 32'(pkt_count), 32'd1);

    // Back-pressure overlap
    out_ready = 1'b0;
    exp_q.push_back(9'd10);
    for (int i = 1; i <= 7; i++) begin
      d = 8'(i);
      send_beat(d, w);
      check("bp_no_wait", 32'(w), 32'd0);
    end
    check("bp_held_valid", 32'(out_valid), 32'd1);
    check("bp_held_sum", 32'(out_sum), 32'd10);
    in_valid = 1'b1; in_data = 8'd8;
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
    check("bp_sum_stable", 32'(out_sum), 32'd10);
    tick();
    exp_q.push_back(9'd26);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_pkt_count_1", 32'(pkt_count), 32'd2);
    check("bp_refill_valid", 32'(out_valid), 32'd1);
    check("bp_refill_sum", 32'(out_sum), 32'd26);
    check("bp_busy_clear", 32'(busy), 32'd0);
    tick();
    check("bp_pkt_count_2", 32'(pkt_count), 32'd3);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Overflow with SUM_W=9
`ifdef SEQ_ACCUM_SATURATE_EN
    exp_q.push_back(9'h1FF);
`else
    exp_q.push_back(9'h1FC);
`endif
    repeat (4) send_beat(8'hFF, w);
    tick(); tick();
    check("ovf_pkt_count", 32'(pkt_count), 32'd4);

    // Mid-packet asynchronous reset
    send_beat(8'd3, w); send_beat(8'd5, w);
    check("mid_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_busy_async", 32'(busy), 32'd0);
    check("mid_out_valid_async", 32'(out_valid), 32'd0);
    check("mid_pkt_count_async", 32'(pkt_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(9'd4);
    repeat (4) send_beat(8'd1, w);
    tick(); tick();
    check("mid_pkt_count_after", 32'(pkt_count), 32'd1);

    // Reset with output FULL discards the pending sum
    out_ready = 1'b0;
    repeat (4) send_beat(8'd9, w);
    check("full_before_reset", 32'(out_valid), 32'd1);
    do_reset();
    check("full_after_reset", 32'(out_valid), 32'd0);
    check("full_sum_after_reset", 32'(out_sum), 32'd0);

    // Random gaps and back-pressure
    rnd_mode = 1'b1;
    for (int p = 0; p < 250; p++) begin
      s = '0;
      for (int b = 0; b < BEATS; b++) begin
        d = 8'($urandom_range(0, 255));
        repeat ($urandom_range(0, 2)) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
        s = model_add(s, d);
        send_beat(d, w);
      end
      exp_q.push_back(s);
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("rand_sb_drained", 32'(exp_q.size()), 32'd0);
    tick();
    check("rand_pkt_count", 32'(pkt_count), 32'd250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
